// File: rtl/uart_rx_if.sv
// Consumer-side handshake bundle for the UART receiver: received byte, valid/ready and error pulses.
// The receiver drives the master side; the consumer (loopback checker or FIFO) sits on the slave side.
interface uart_rx_if #(
    parameter int DBIT = 8
);
    logic [DBIT-1:0] o_rx_data;
    logic            o_rx_valid;
    logic            i_rx_ready;
    logic            o_frame_err;
    logic            o_overrun_err;

    modport master (
        output o_rx_data,
        output o_rx_valid,
        output o_frame_err,
        output o_overrun_err,
        input  i_rx_ready
    );

    modport slave (
        input  o_rx_data,
        input  o_rx_valid,
        input  o_frame_err,
        input  o_overrun_err,
        output i_rx_ready
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 2-FF line synchronizer, 16x oversampling divider, start/data/stop FSM and a
// one-entry holding register with valid/ready handshake plus framing and overrun error pulses.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int CLK_DIV = 163,
    parameter int NB_DIV  = 8
) (
    input  logic    i_clock,
    input  logic    i_reset,
    input  logic    i_rx,
    uart_rx_if.master rx_bus
);

    localparam int NB_N = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [NB_DIV-1:0] DIV_LAST  = NB_DIV'(CLK_DIV - 1);
    localparam logic [NB_N-1:0]   N_LAST    = NB_N'(DBIT - 1);
    localparam logic [3:0]        S_MID     = 4'd7;
    localparam logic [3:0]        S_BIT_END = 4'd15;
    localparam logic [3:0]        S_STOP    = 4'(SB_TICK - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t            state, state_next;
    logic              rx_meta, rx_s;
    logic [NB_DIV-1:0] div_cnt;
    logic              tick;
    logic [3:0]        s, s_next;
    logic [NB_N-1:0]   n, n_next;
    logic [DBIT-1:0]   shift, shift_next;
    logic              deliver;
    logic              frame_bad;

    logic [DBIT-1:0]   rx_data_q;
    logic              rx_valid_q;
    logic              frame_err_q;
    logic              overrun_err_q;

    // Line synchronizer: both stages reset to the idle-high level
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + NB_DIV'(1);
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
            s     <= '0;
            n     <= '0;
            shift <= '0;
        end else begin
            state <= state_next;
            s     <= s_next;
            n     <= n_next;
            shift <= shift_next;
        end
    end

    always_comb begin
        state_next = state;
        s_next     = s;
        n_next     = n;
        shift_next = shift;
        deliver    = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            IDLE: begin
                // Level check every clock so the start edge is caught without tick jitter
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s == S_MID) begin
                        if (!rx_s) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s == S_BIT_END) begin
                        shift_next = {rx_s, shift[DBIT-1:1]};
                        s_next     = '0;
                        if (n == N_LAST) begin
                            state_next = STOP;
                        end else begin
                            n_next = n + NB_N'(1);
                        end
                    end else begin
                        s_next = s + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s == S_STOP) begin
                        if (rx_s) begin
                            deliver    = 1'b1;
                            state_next = IDLE;
                        end else begin
                            frame_bad  = 1'b1;
                            state_next = WAIT_HIGH;
                        end
                    end else begin
                        s_next = s + 4'd1;
                    end
                end
            end
            WAIT_HIGH: begin
                // A held-low line (break) must not be read as a string of new start bits
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Holding register: a simultaneous accept frees the slot for the incoming byte
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            frame_err_q   <= frame_bad;
            overrun_err_q <= 1'b0;
            if (deliver) begin
                if (!rx_valid_q || rx_bus.i_rx_ready) begin
                    rx_data_q  <= shift;
                    rx_valid_q <= 1'b1;
                end else begin
                    overrun_err_q <= 1'b1;
                end
            end else if (rx_valid_q && rx_bus.i_rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx_bus.o_rx_data     = rx_data_q;
    assign rx_bus.o_rx_valid    = rx_valid_q;
    assign rx_bus.o_frame_err   = frame_err_q;
    assign rx_bus.o_overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a shortened divider so each bit spans 64 system clocks.
module tb_uart_rx;
    localparam int DBIT     = 8;
    localparam int SB_TICK  = 16;
    localparam int CLK_DIV  = 4;
    localparam int NB_DIV   = 3;
    localparam int BIT_CLKS = 16 * CLK_DIV;

    logic clk = 1'b0;
    logic rst_n;
    logic rx;

    uart_rx_if #(.DBIT(DBIT)) bus();

    uart_rx #(
        .DBIT    (DBIT),
        .SB_TICK (SB_TICK),
        .CLK_DIV (CLK_DIV),
        .NB_DIV  (NB_DIV)
    ) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .i_rx    (rx),
        .rx_bus  (bus.master)
    );

    always #10 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int ferr_cnt = 0, ovr_cnt = 0, both_cnt = 0, rise_cnt = 0, acc_cnt = 0;
    logic [7:0] acc_data = 8'h00;
    logic prev_valid = 1'b0;
    int f0, o0, r0, a0;

    // Event monitor on the falling edge, clear of the DUT's active edge
    always @(negedge clk) begin
        if (bus.o_frame_err) ferr_cnt++;
        if (bus.o_overrun_err) ovr_cnt++;
        if (bus.o_frame_err && bus.o_overrun_err) both_cnt++;
        if (bus.o_rx_valid && !prev_valid) rise_cnt++;
        if (bus.o_rx_valid && bus.i_rx_ready) begin
            acc_cnt++;
            acc_data = bus.o_rx_data;
        end
        prev_valid = bus.o_rx_valid;
    end

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic snap();
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        r0 = rise_cnt;
        a0 = acc_cnt;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        clks(BIT_CLKS);
    endtask

    // Leaves the line at the stop-bit level so a caller can extend a low stop bit
    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    initial begin
        int k;
        rx = 1'b1;
        rst_n = 1'b0;
        bus.i_rx_ready = 1'b1;
        clks(5);
        chk("reset_valid", int'(bus.o_rx_valid), 0);
        chk("reset_data", int'(bus.o_rx_data), 0);
        chk("reset_ferr", int'(bus.o_frame_err), 0);
        chk("reset_ovr", int'(bus.o_overrun_err), 0);
        rst_n = 1'b1;
        clks(5);

        // Single frame, consumer always ready
        snap();
        send_frame(8'h55, 1'b1);
        clks(8);
        chk("t1_valid_rise", rise_cnt - r0, 1);
        chk("t1_accepts", acc_cnt - a0, 1);
        chk("t1_data", int'(acc_data), 'h55);
        chk("t1_ferr", ferr_cnt - f0, 0);
        chk("t1_ovr", ovr_cnt - o0, 0);
        chk("t1_valid_clear", int'(bus.o_rx_valid), 0);

        // Back-to-back frames with consumer stalled: overrun keeps the first byte
        bus.i_rx_ready = 1'b0;
        snap();
        send_frame(8'h01, 1'b1);
        send_frame(8'h20, 1'b1);
        clks(8);
        chk("t2_valid_held", int'(bus.o_rx_valid), 1);
        chk("t2_data_held", int'(bus.o_rx_data), 'h01);
        chk("t2_ovr", ovr_cnt - o0, 1);
        chk("t2_ferr", ferr_cnt - f0, 0);
        chk("t2_no_accept", acc_cnt - a0, 0);
        bus.i_rx_ready = 1'b1;
        clks(2);
        chk("t2_valid_clear", int'(bus.o_rx_valid), 0);
        chk("t2_accepts", acc_cnt - a0, 1);
        chk("t2_acc_data", int'(acc_data), 'h01);

        // Low stop bit followed by a held-low line
        snap();
        send_frame(8'h20, 1'b0);
        clks(BIT_CLKS);
        chk("t3_ferr_mid_break", ferr_cnt - f0, 1);
        clks(2 * BIT_CLKS);
        rx = 1'b1;
        clks(BIT_CLKS);
        chk("t3_ferr", ferr_cnt - f0, 1);
        chk("t3_no_valid", rise_cnt - r0, 0);
        chk("t3_ovr", ovr_cnt - o0, 0);
        chk("t3_valid_low", int'(bus.o_rx_valid), 0);
        snap();
        send_frame(8'hA5, 1'b1);
        clks(8);
        chk("t3_next_rise", rise_cnt - r0, 1);
        chk("t3_next_data", int'(acc_data), 'hA5);
        chk("t3_next_ferr", ferr_cnt - f0, 0);

        // Short low glitch on an idle line
        snap();
        rx = 1'b0;
        clks(16);
        rx = 1'b1;
        clks(2 * BIT_CLKS);
        chk("t4_no_valid", rise_cnt - r0, 0);
        chk("t4_no_ferr", ferr_cnt - f0, 0);
        chk("t4_no_ovr", ovr_cnt - o0, 0);

        // Reset during the fourth data bit of 0xFF, then a clean 0x3C frame
        snap();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        clks(BIT_CLKS / 2);
        rst_n = 1'b0;
        clks(1);
        chk("t5_rst_data", int'(bus.o_rx_data), 0);
        chk("t5_rst_valid", int'(bus.o_rx_valid), 0);
        chk("t5_rst_flags", int'(bus.o_frame_err) + int'(bus.o_overrun_err), 0);
        clks(5);
        rst_n = 1'b1;
        clks(6 * BIT_CLKS);
        chk("t5_no_spurious", rise_cnt - r0, 0);
        chk("t5_no_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
        snap();
        send_frame(8'h3C, 1'b1);
        clks(8);
        chk("t5_rise", rise_cnt - r0, 1);
        chk("t5_data", int'(acc_data), 'h3C);
        chk("t5_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);

        // Accept in the delivery cycle: no overrun, byte replaced, valid stays up
        bus.i_rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        clks(8);
        chk("t6_first_valid", int'(bus.o_rx_valid), 1);
        chk("t6_first_data", int'(bus.o_rx_data), 'h11);
        snap();
        k = 0;
        fork
            send_frame(8'h22, 1'b1);
            begin
                while (!dut.deliver && k < 2000) begin
                    clks(1);
                    k++;
                end
                bus.i_rx_ready = 1'b1;
                clks(1);
                bus.i_rx_ready = 1'b0;
            end
        join
        chk("t6_sync", (k < 2000) ? 1 : 0, 1);
        clks(8);
        chk("t6_valid_kept", int'(bus.o_rx_valid), 1);
        chk("t6_data_new", int'(bus.o_rx_data), 'h22);
        chk("t6_no_ovr", ovr_cnt - o0, 0);
        chk("t6_accepts", acc_cnt - a0, 1);
        chk("t6_acc_old", int'(acc_data), 'h11);
        bus.i_rx_ready = 1'b1;
        clks(2);
        chk("t6_valid_clear", int'(bus.o_rx_valid), 0);

        chk("flags_exclusive", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, downstream of the UART transmitter; consumes the serial line that the transmitter drives on o_tx.
- Contains its own 16x oversampling baud-tick divider, a 2-FF input synchronizer, the receive FSM, and a one-entry output holding register with a valid/ready handshake toward the consumer (loopback checker or future FIFO).
- Flags framing errors and overrun errors.

Parameters:
- DBIT, 8, data bits per frame, sent LSB first, no parity.
- SB_TICK, 16, oversampling ticks spent in the stop bit (16 = 1 stop bit).
- CLK_DIV, 163, system clocks per oversampling tick (50 MHz / (19200*16)).
- NB_DIV, 8, width of the divider counter; must satisfy 2^NB_DIV >= CLK_DIV.

Ports:
- i_clock  in  1  system clock, 50 MHz.
- i_reset  in  1  asynchronous, active-low reset (0 = reset).
- i_rx  in  1  serial line, idle high, asynchronous to i_clock.
- i_rx_ready  in  1  consumer accepts o_rx_data when high together with o_rx_valid.
- o_rx_data  out  DBIT  received byte.
- o_rx_valid  out  1  o_rx_data holds an unconsumed byte.
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- o_overrun_err  out  1  one-cycle pulse: byte completed while holding register was still full.

Behaviour:
- Reset (i_reset=0, asynchronous): FSM=IDLE, divider=0, synchronizer FFs=1, shift reg=0, o_rx_data=0, o_rx_valid=0, o_frame_err=0, o_overrun_err=0.
- Synchronizer: i_rx passes through 2 FFs; rx_s is the output. The FSM sees only rx_s, so line edges appear 2 clocks late.
- Divider: free-running counter 0..CLK_DIV-1. tick=1 for the single cycle in which count==CLK_DIV-1; count then wraps to 0.
- Tick counter s (4 bits) and bit counter n (log2 DBIT bits) advance only on tick.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: when rx_s==0, go to START and set s=0. This is level-checked every clock, not only on tick.
- START: on tick, if s==7, sample rx_s at mid-bit.
  - rx_s==0: go to DATA with s=0, n=0.
  - rx_s==1: glitch; go to IDLE with no flag.
  - Otherwise s++.
- DATA: on tick, if s==15, shift rx_s into the shift register MSB side (shift right), set s=0.
  - If n==DBIT-1, go to STOP; else n++.
  - Otherwise s++.
- STOP: on tick, if s==SB_TICK-1, sample rx_s.
  - rx_s==1: frame good; deliver the byte (see below) and go to IDLE.
  - rx_s==0: pulse o_frame_err, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then go to IDLE. This prevents a line break from retriggering frames.
- Delivery happens in the cycle after the stop-sample tick:
  - If o_rx_valid==0, or o_rx_valid & i_rx_ready in that same cycle: o_rx_data<=shift reg, o_rx_valid<=1.
  - Else: o_rx_data is unchanged (old byte kept), o_overrun_err pulses, new byte dropped.
- Handshake: o_rx_valid stays high until a cycle with i_rx_ready=1, then clears next edge, unless a delivery occurs in that same cycle (valid stays 1, data replaced). o_rx_data is stable while valid and not accepted.
- Error flags are single-cycle pulses and are never asserted together.
- Reset asserted mid-frame: immediate return to reset values; any partial byte is lost. After release, the FSM waits in IDLE for the next low level.
- Latency: from the stop-bit mid-sample tick to o_rx_valid high is 1 clock. Start-bit falling edge to valid is about 9.5 bit times plus 3 clocks.
- Bit time at defaults: 16*163*20 ns = 52.16 us.

Test Plan:
- Reset, then drive frame 0x55 (start 0, bits LSB first, stop 1) at 52.16 us per bit with i_rx_ready=1 -> o_rx_valid pulses 1 cycle, o_rx_data=0x55, no error flags.
- Frames 0x01 then 0x20 back to back, i_rx_ready=0 until after the second frame -> first byte 0x01 held and valid; second completion pulses o_overrun_err; o_rx_data stays 0x01. Asserting ready clears valid.
- 0x20 frame with the stop bit forced low, line held low for 3 bit times, then released -> o_frame_err pulse, o_rx_valid stays 0, no new frame until the line returns high; a following 0xA5 frame is received correctly.
- 1 us low glitch on an idle line -> START rejects it at mid-bit, FSM returns to IDLE, no valid, no flags.
- i_reset pulled low during the 4th data bit of 0xFF, released, then frame 0x3C sent -> outputs at reset values during reset; 0x3C received correctly with no spurious byte.
- Delivery with o_rx_valid=1 and i_rx_ready=1 in the delivery cycle -> no overrun; valid stays high and data updates to the new byte.
